uart_tx_fifo: RTL and testbench

//  CPU-side UART transmitter: the write end of the WRITE_UART path. The CPU targets the UART

---
 rtl/uart_tx_fifo_if.sv | 25 ++
 rtl/uart_tx_fifo.sv | 118 +++++++++++
 tb/tb_uart_tx_fifo.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// CPU-side bundle of the UART transmitter: write byte and strobe in; serial line and status out.
// The master drives the write side; the slave (the transmitter) drives line and status.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [7:0]    data;
  logic          _uart_in;
  logic          _flag_do;
  logic          tx;
  logic          busy;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  modport master (
    output data, _uart_in,
    input  _flag_do, tx, busy, overflow, fifo_count
  );

  modport slave (
    input  data, _uart_in,
    output _flag_do, tx, busy, overflow, fifo_count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter behind a small write FIFO; a byte written into an empty idle FIFO starts its
// frame one edge later. Writes to a full FIFO are dropped (sticky overflow) unless a pop frees a slot.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           mr,
  uart_tx_fifo_if.slave uart
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q;
  logic          div_last, fifo_empty, wr_req, push, pop;

  assign div_last   = (div_q == DIV_LAST);
  assign fifo_empty = (count_q == '0);
  assign wr_req     = ~uart._uart_in;

  always_comb begin
    state_d = state_q;
    div_d   = div_last ? '0 : div_q + DW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
        end
      end
      START: begin
        if (div_last) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (div_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Reloading straight from the FIFO keeps consecutive frames gap-free.
        if (div_last) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop on the same edge frees the slot, so a write into a full FIFO is still accepted.
  assign push = wr_req & ((count_q != FULL) | pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (wr_req && !push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= uart.data;
  end

  assign uart.tx         = (state_q == START) ? 1'b0 :
                           (state_q == DATA)  ? shift_q[0] : 1'b1;
  assign uart.busy       = (state_q != IDLE) | ~fifo_empty;
  assign uart.overflow   = overflow_q;
  assign uart.fifo_count = count_q;
  assign uart._flag_do   = (count_q == FULL);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued at write time and compared against
// every cycle of each frame decoded from tx; directed checks cover timing, FIFO limits and reset.
module tb_uart_tx_fifo;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int FRAME   = 10 * CLK_DIV;

  logic clk;
  logic mr;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   cyc    = 0;
  int   frames = 0;
  int   n0, f0, s0;
  logic [7:0] exp_q[$];
  int         starts[$];
  int         exp_cnt[6] = '{1, 1, 2, 3, 4, 4};

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) uart ();

  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .mr   (mr),
    .uart (uart)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame monitor: a low tx while idle opens a frame; every cycle is compared to the expected byte.
  initial begin : monitor
    int         k;
    int         slot;
    bit         act;
    logic       expbit;
    logic [7:0] byte_v;
    act    = 1'b0;
    k      = 0;
    byte_v = '0;
    forever begin
      @(negedge clk);
      if (mr) begin
        act = 1'b0;
      end else begin
        if (!act && uart.tx === 1'b0) begin
          act = 1'b1;
          k   = 0;
          frames++;
          starts.push_back(cyc);
          chk("frame_expected", 32'(exp_q.size() != 0), 1);
          byte_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        end
        if (act) begin
          slot = k / CLK_DIV;
          if (slot == 0)      expbit = 1'b0;
          else if (slot == 9) expbit = 1'b1;
          else                expbit = byte_v[slot-1];
          chk($sformatf("frame%0d_byte%02h_k%0d", frames, byte_v, k), uart.tx, expbit);
          k++;
          if (k == FRAME) act = 1'b0;
        end
      end
    end
  end

  task automatic wr(input logic [7:0] b, input bit acc);
    uart.data     = b;
    uart._uart_in = 1'b0;
    if (acc) exp_q.push_back(b);
    @(negedge clk);
    uart._uart_in = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (uart.busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("idle_timeout", uart.busy, 0);
  endtask

  // Reset asserted between clock edges; outputs must respond before the next edge.
  task automatic pulse_mr(input string p);
    #2 mr = 1'b1;
    #1;
    chk({p, "_rst_tx"}, uart.tx, 1);
    chk({p, "_rst_busy"}, uart.busy, 0);
    chk({p, "_rst_overflow"}, uart.overflow, 0);
    chk({p, "_rst_count"}, uart.fifo_count, 0);
    chk({p, "_rst_flag"}, uart._flag_do, 0);
    exp_q.delete();
    @(negedge clk);
    #2 mr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got cycle %0d expected finish before it", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    mr            = 1'b1;
    uart.data     = 8'h00;
    uart._uart_in = 1'b1;
    repeat (3) @(negedge clk);
    #2 mr = 1'b0;
    @(negedge clk);
    chk("init_tx", uart.tx, 1);
    chk("init_busy", uart.busy, 0);
    chk("init_count", uart.fifo_count, 0);
    chk("init_flag", uart._flag_do, 0);
    chk("init_overflow", uart.overflow, 0);

    // Reset in the middle of a frame.
    wr(8'h55, 1'b1);
    repeat (12) @(negedge clk);
    pulse_mr("t1");
    f0 = frames;
    repeat (2 * CLK_DIV) @(negedge clk);
    chk("t1_tx_idle", uart.tx, 1);
    chk("t1_busy_idle", uart.busy, 0);
    chk("t1_no_frame", frames - f0, 0);

    // Single byte: start one edge after the write, busy falls one frame later.
    f0 = frames;
    wr(8'hA5, 1'b1);
    n0 = cyc;
    chk("t2_count_after_wr", uart.fifo_count, 1);
    chk("t2_tx_before_pop", uart.tx, 1);
    chk("t2_busy_after_wr", uart.busy, 1);
    @(negedge clk);
    chk("t2_start_bit", uart.tx, 0);
    chk("t2_count_after_pop", uart.fifo_count, 0);
    wait_idle(100);
    chk("t2_busy_fall", cyc - (n0 + 1), FRAME);
    chk("t2_frames", frames - f0, 1);
    chk("t2_drained", exp_q.size(), 0);

    // Back-to-back frames.
    s0 = starts.size();
    wr(8'h01, 1'b1);
    wr(8'h80, 1'b1);
    wait_idle(200);
    chk("t3_frames", starts.size() - s0, 2);
    if (starts.size() >= s0 + 2) chk("t3_gap", starts[s0+1] - starts[s0], FRAME);
    chk("t3_drained", exp_q.size(), 0);

    // Six writes on consecutive edges: the last is dropped.
    f0 = frames;
    for (int i = 0; i < 6; i++) begin
      wr(8'h10 + 8'(i), i < 5);
      chk($sformatf("t4_count_%0d", i), uart.fifo_count, exp_cnt[i]);
      chk($sformatf("t4_flag_%0d", i), uart._flag_do, 32'(i >= 4));
      chk($sformatf("t4_overflow_%0d", i), uart.overflow, 32'(i == 5));
    end
    wait_idle(400);
    chk("t4_frames", frames - f0, 5);
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_overflow_sticky", uart.overflow, 1);

    // Write into a full FIFO on the edge the STOP bit ends.
    pulse_mr("t5");
    f0 = frames;
    wr(8'hC1, 1'b1);
    n0 = cyc;
    @(negedge clk);
    for (int i = 0; i < 4; i++) wr(8'hD0 + 8'(i), 1'b1);
    chk("t5_full_count", uart.fifo_count, 4);
    chk("t5_full_flag", uart._flag_do, 1);
    while (cyc < n0 + FRAME) @(negedge clk);
    chk("t5_count_before", uart.fifo_count, 4);
    wr(8'hE7, 1'b1);
    chk("t5_count_after", uart.fifo_count, 4);
    chk("t5_overflow", uart.overflow, 0);
    chk("t5_flag_after", uart._flag_do, 1);
    wait_idle(400);
    chk("t5_frames", frames - f0, 6);
    chk("t5_drained", exp_q.size(), 0);

    // Reset during data bit 3, then a fresh byte.
    f0 = frames;
    wr(8'h11, 1'b1);
    n0 = cyc;
    wr(8'h22, 1'b1);
    while (cyc < n0 + 1 + 4 * CLK_DIV + 1) @(negedge clk);
    chk("t6_in_bit3", uart.tx, 0);
    pulse_mr("t6");
    repeat (12 * CLK_DIV) @(negedge clk);
    chk("t6_lost_queue", frames - f0, 1);
    chk("t6_tx_idle", uart.tx, 1);
    wr(8'h3C, 1'b1);
    wait_idle(100);
    chk("t6_frames", frames - f0, 2);
    chk("t6_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
